// File: rtl/serial_to_parallel_multi.sv
// Multi-lane deserializer: packs LANES-bit beats into WIDTH-bit words, with
// selectable bit order, ready/valid on both sides and early close via last.
module serial_to_parallel_multi #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial_valid,
  output logic                         serial_ready,
  input  logic [LANES-1:0]             serial_data,
  input  logic                         serial_last,
  output logic                         parallel_valid,
  input  logic                         parallel_ready,
  output logic [WIDTH-1:0]             parallel_data,
  output logic                         parallel_last,
  output logic [$clog2(WIDTH+1)-1:0]   parallel_bits
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = $clog2(BEATS);
  localparam int BW    = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] beat_word;
  logic [BW-1:0]    bits_next;
  logic             accept;
  logic             complete;

  // Handshake: a transfer happens on a rising edge where valid && ready on the
  // same side. valid never waits for ready; once the output word is valid it and
  // its data/bits/last hold until taken. serial_ready depends only on the output
  // register state and parallel_ready, so a free output slot (or one being
  // drained this cycle) is the sole condition for taking a beat.
  assign serial_ready = !parallel_valid || parallel_ready;
  assign accept       = serial_valid && serial_ready;
  assign complete     = accept && ((cnt == CW'(BEATS - 1)) || serial_last);
  assign bits_next    = BW'((32'(cnt) + 32'd1) * 32'(LANES));

  // Place the incoming beat into its slot; slots fill upward or downward.
  always_comb begin
    beat_word = '0;
    for (int s = 0; s < BEATS; s++) begin
      if (cnt == CW'(s)) begin
        if (MSB_FIRST) begin
          beat_word[WIDTH-(s+1)*LANES +: LANES] = serial_data;
        end else begin
          beat_word[s*LANES +: LANES] = serial_data;
        end
      end
    end
  end

  // Accumulator and beat counter; cleared on every word completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      if (complete) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        acc <= acc | beat_word;
      end
    end
  end

  // Output register: a completing beat loads it even while the old word drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_valid <= 1'b0;
      parallel_data  <= '0;
      parallel_last  <= 1'b0;
      parallel_bits  <= '0;
    end else begin
      if (complete) begin
        parallel_valid <= 1'b1;
        parallel_data  <= acc | beat_word;
        parallel_last  <= serial_last;
        parallel_bits  <= bits_next;
      end else if (parallel_valid && parallel_ready) begin
        parallel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_multi.sv
// Bench for serial_to_parallel_multi: three configurations share one stimulus
// stream and are compared every cycle against a bit-stream reference model.
module tb_serial_to_parallel_multi;

  logic              clk = 1'b0;
  logic              rst;
  logic              serial_valid;
  logic              serial_last;
  logic              parallel_ready;
  logic [1:0]        serial_data;
  logic [2:0]        sready;
  logic [2:0]        pvalid;
  logic [2:0]        plast;
  logic [2:0][7:0]   pdata;
  logic [2:0][3:0]   pbits;

  // clock / reset
  always #5 clk = ~clk;

  serial_to_parallel_multi #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .serial_valid(serial_valid), .serial_ready(sready[0]),
    .serial_data(serial_data[0]), .serial_last(serial_last),
    .parallel_valid(pvalid[0]), .parallel_ready(parallel_ready),
    .parallel_data(pdata[0]), .parallel_last(plast[0]), .parallel_bits(pbits[0]));

  serial_to_parallel_multi #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .serial_valid(serial_valid), .serial_ready(sready[1]),
    .serial_data(serial_data), .serial_last(serial_last),
    .parallel_valid(pvalid[1]), .parallel_ready(parallel_ready),
    .parallel_data(pdata[1]), .parallel_last(plast[1]), .parallel_bits(pbits[1]));

  serial_to_parallel_multi #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .serial_valid(serial_valid), .serial_ready(sready[2]),
    .serial_data(serial_data[0]), .serial_last(serial_last),
    .parallel_valid(pvalid[2]), .parallel_ready(parallel_ready),
    .parallel_data(pdata[2]), .parallel_last(plast[2]), .parallel_bits(pbits[2]));

  // reference model: bits kept in arrival order, packed only when a word closes
  logic [7:0] m_stream [3];
  int         m_n      [3];
  logic       m_pv     [3];
  logic [7:0] m_data   [3];
  int         m_bits   [3];
  logic       m_last   [3];
  int         bits_in  [3];
  int         bits_out [3];
  int         beats_a;
  int         words_a;
  logic [7:0] exp_q[$];

  int checks = 0;
  int passes = 0;

  function automatic int lanes_of(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic bit msb_of(int i);
    return (i != 0);
  endfunction

  function automatic logic [7:0] pack(int i);
    logic [7:0] w = '0;
    for (int j = 0; j < m_n[i]; j++) begin
      if (msb_of(i)) w[7-j] = m_stream[i][j];
      else           w[j]   = m_stream[i][j];
    end
    return w;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_stream[i] = '0; m_n[i] = 0; m_pv[i] = 1'b0; m_data[i] = '0;
      m_bits[i] = 0; m_last[i] = 1'b0; bits_in[i] = 0; bits_out[i] = 0;
    end
    beats_a = 0;
    words_a = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pvalid%0d", i), 32'(pvalid[i]), 32'(m_pv[i]));
      if (m_pv[i]) begin
        chk($sformatf("pdata%0d", i), 32'(pdata[i]), 32'(m_data[i]));
        chk($sformatf("pbits%0d", i), 32'(pbits[i]), 32'(m_bits[i]));
        chk($sformatf("plast%0d", i), 32'(plast[i]), 32'(m_last[i]));
      end
    end
  endtask

  // driver: one clock cycle starting and ending at a falling edge
  task automatic cycle(input logic v, input logic [1:0] d, input logic l, input logic pr);
    logic exp_ready;
    logic bit_v;
    serial_valid = v; serial_data = d; serial_last = l; parallel_ready = pr;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_ready = !m_pv[i] || pr;
      chk($sformatf("sready%0d", i), 32'(sready[i]), 32'(exp_ready));
      if (pvalid[i] && pr) begin
        bits_out[i] += int'(pbits[i]);
        if (i == 0) begin
          words_a++;
          if (exp_q.size() == 0) chk("sb_unexpected_word", 32'(pdata[0]), 32'hFFFF_FFFF);
          else chk("sb_word", 32'(pdata[0]), 32'(exp_q.pop_front()));
        end
      end
      if (m_pv[i] && pr) m_pv[i] = 1'b0;
      if (v && exp_ready) begin
        for (int b = 0; b < lanes_of(i); b++) begin
          bit_v = msb_of(i) ? d[lanes_of(i)-1-b] : d[b];
          m_stream[i][m_n[i]] = bit_v;
          m_n[i]++;
        end
        bits_in[i] += lanes_of(i);
        if (i == 0) beats_a++;
        if (m_n[i] == 8 || l) begin
          m_data[i] = pack(i);
          m_bits[i] = m_n[i];
          m_last[i] = l;
          m_pv[i]   = 1'b1;
          if (i == 0) exp_q.push_back(m_data[i]);
          m_n[i] = 0;
          m_stream[i] = '0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    serial_valid = 1'b0; serial_data = '0; serial_last = 1'b0; parallel_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pvalid%0d", i), 32'(pvalid[i]), 32'd0);
      chk($sformatf("rst_pdata%0d", i), 32'(pdata[i]), 32'd0);
      chk($sformatf("rst_pbits%0d", i), 32'(pbits[i]), 32'd0);
      chk($sformatf("rst_plast%0d", i), 32'(plast[i]), 32'd0);
      chk($sformatf("rst_sready%0d", i), 32'(sready[i]), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] bits_v, input int n, input logic pr);
    for (int j = 0; j < n; j++) cycle(1'b1, {1'b0, bits_v[j]}, 1'b0, pr);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b0;
    serial_valid = 1'b0; serial_data = '0; serial_last = 1'b0; parallel_ready = 1'b0;
    model_reset();

    // reset and LSB-first packing: stream 1,0,1,1,0,0,0,1
    do_reset();
    send_bits(8'b1000_1101, 8, 1'b1);
    chk("lsb_word", 32'(pdata[0]), 32'h8D);
    chk("lsb_bits", 32'(pbits[0]), 32'd8);
    chk("lsb_last", 32'(plast[0]), 32'd0);
    chk("lsb_valid", 32'(pvalid[0]), 32'd1);

    // MSB-first, two lanes: beats 10,11,00,01
    do_reset();
    cycle(1'b1, 2'b10, 1'b0, 1'b1);
    cycle(1'b1, 2'b11, 1'b0, 1'b1);
    cycle(1'b1, 2'b00, 1'b0, 1'b1);
    cycle(1'b1, 2'b01, 1'b0, 1'b1);
    chk("msb2_word", 32'(pdata[1]), 32'hB1);
    chk("msb2_bits", 32'(pbits[1]), 32'd8);

    // partial word closed by last: 1,1,0
    do_reset();
    cycle(1'b1, 2'b01, 1'b0, 1'b1);
    cycle(1'b1, 2'b01, 1'b0, 1'b1);
    cycle(1'b1, 2'b00, 1'b1, 1'b1);
    chk("part_lsb_word", 32'(pdata[0]), 32'h03);
    chk("part_lsb_bits", 32'(pbits[0]), 32'd3);
    chk("part_lsb_last", 32'(plast[0]), 32'd1);
    chk("part_msb_word", 32'(pdata[2]), 32'hC0);
    send_bits(8'b0000_0001, 8, 1'b1);
    chk("after_part_word", 32'(pdata[0]), 32'h01);
    chk("after_part_bits", 32'(pbits[0]), 32'd8);

    // backpressure: word completes under parallel_ready=0, then 5 stalled cycles
    do_reset();
    send_bits(8'b1001_0110, 8, 1'b0);
    held = 8'h96;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 2'b01, 1'b0, 1'b0);
      chk("stall_sready", 32'(sready[0]), 32'd0);
      chk("stall_data", 32'(pdata[0]), 32'(held));
    end
    cycle(1'b1, 2'b01, 1'b0, 1'b1);

    // simultaneous drain of word A and completion of a one-beat word B
    send_bits(8'b0101_0101, 6, 1'b1);
    cycle(1'b1, 2'b00, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    chk("simul_a_pending", 32'(pvalid[0]), 32'd1);
    cycle(1'b1, 2'b01, 1'b1, 1'b1);
    chk("simul_b_valid", 32'(pvalid[0]), 32'd1);
    chk("simul_b_word", 32'(pdata[0]), 32'h01);
    chk("simul_b_bits", 32'(pbits[0]), 32'd1);
    for (int c = 0; c < 3; c++) cycle(1'b1, 2'(c), 1'b1, 1'b1);
    cycle(1'b0, 2'b00, 1'b0, 1'b1);
    chk("b2b_conserve_a", 32'(bits_out[0]), 32'(bits_in[0]));

    // reset mid-word: five stale bits then a fresh word 1,0,1,0,0,1,0,1
    do_reset();
    send_bits(8'b0001_1111, 5, 1'b1);
    do_reset();
    send_bits(8'b1010_0101, 8, 1'b1);
    chk("post_rst_word", 32'(pdata[0]), 32'hA5);

    // random soak
    for (int c = 0; c < 800; c++)
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0,
            1'($urandom_range(0, 3) != 0));
    for (int c = 0; c < 3; c++) cycle(1'b0, 2'b00, 1'b0, 1'b1);
    chk("soak_words_x8", 32'(words_a * 8 + m_n[0]), 32'(beats_a));
    cycle(1'b1, 2'b00, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) cycle(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("conserve%0d", i), 32'(bits_out[i]), 32'(bits_in[i]));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
